psg_stereo_gen2: RTL and testbench

//  Second-generation SN76489-compatible PSG core: NUM_TONE square-wave tone channels plus one noise

---
 rtl/psg_pkg.sv | 49 ++++
 rtl/psg_tone_gen.sv | 53 +++++
 rtl/psg_stereo_gen2.sv | 222 ++++++++++++++++++++++
 tb/tb_psg_stereo_gen2.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// psg_pkg: shared constants, types and the attenuation-to-amplitude table
// for the psg_stereo_gen2 sound generator.
//   CH_NOISE    byte-protocol channel number of the noise generator
//   NUM_CH      channel slots addressed by the attenuation/pan registers
//   noise_rate_e noise shift-rate selector (3 fixed rates or tone-driven)
//   amp_table() amplitude for a 4-bit attenuation, 2 dB per step
package psg_pkg;

  localparam logic [1:0] CH_NOISE = 2'd3;
  localparam int         NUM_CH   = 4;

  typedef enum logic [1:0] {
    NS_512  = 2'd0,
    NS_1024 = 2'd1,
    NS_2048 = 2'd2,
    NS_TONE = 2'd3
  } noise_rate_e;

  // Amplitude for attenuation att at an out_w-bit mix. Full scale per channel
  // is 2^(out_w-2)-1 so four channels fit in the output word. Each step
  // multiplies by 10^(-0.1) (2 dB); the ratios are held as Q16 constants and
  // the product is truncated. Attenuation 15 is silence.
  function automatic logic [31:0] amp_table(input logic [3:0] att,
                                            input int unsigned out_w);
    logic [63:0] frac;
    logic [63:0] full;
    case (att)
      4'd0:    frac = 64'd65536;
      4'd1:    frac = 64'd52057;
      4'd2:    frac = 64'd41350;
      4'd3:    frac = 64'd32846;
      4'd4:    frac = 64'd26090;
      4'd5:    frac = 64'd20724;
      4'd6:    frac = 64'd16462;
      4'd7:    frac = 64'd13076;
      4'd8:    frac = 64'd10387;
      4'd9:    frac = 64'd8250;
      4'd10:   frac = 64'd6554;
      4'd11:   frac = 64'd5206;
      4'd12:   frac = 64'd4135;
      4'd13:   frac = 64'd3285;
      4'd14:   frac = 64'd2609;
      default: frac = 64'd0;
    endcase
    full = ((64'd1 << (out_w - 32'd2)) - 64'd1) * frac;
    return 32'(full >> 16);
  endfunction

endpackage

// File: rtl/psg_tone_gen.sv
// psg_tone_gen: one square-wave tone channel.
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        one-cycle generator tick from the shared divider
//   period      reload value for the down-counter
//   bit_out     current square-wave level (1 after reset)
//   rise        one-cycle pulse in the cycle the level goes 0 -> 1
// The counter only samples period when it reloads at zero, so a period
// change lands at the next reload. Periods 0 and 1 pin the level at 1,
// which is what sample-playback code relies on.
module psg_tone_gen #(
  parameter int TONE_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [TONE_W-1:0] period,
  output logic              bit_out,
  output logic              rise
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic              bit_q, bit_d;

  always_comb begin
    cnt_d = cnt_q;
    bit_d = bit_q;
    if (tick) begin
      if (cnt_q == '0) begin
        cnt_d = period;
        bit_d = ~bit_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      if (period < TONE_W'(2)) begin
        bit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bit_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
    end
  end

  assign bit_out = bit_q;
  assign rise    = ~bit_q & bit_d;

endmodule

// File: rtl/psg_stereo_gen2.sv
// psg_stereo_gen2: SN76489-compatible PSG with periodic/white noise,
// selectable noise rate and per-channel stereo panning.
//   in_clk     system clock
//   in_rst_n   asynchronous active-low reset (released synchronously)
//   in_val     byte for the PSG byte decoder or the pan register
//   in_wr      PSG write: a 0 -> 1 change of in_wr accepts in_val once
//   in_pan_wr  pan write: in_val is stored in every cycle this is high
//   out_l      registered, saturating left mix
//   out_r      registered, saturating right mix
// Write protocol: there is no ready; a PSG byte is consumed on the cycle
// in_wr is seen high after being low the previous cycle, and holding in_wr
// high does not repeat the write. in_pan_wr is a level strobe. Both may be
// asserted in the same cycle and then both take the same in_val.
module psg_stereo_gen2
  import psg_pkg::*;
#(
  parameter int NUM_TONE = 3,
  parameter int TONE_W   = 10,
  parameter int CLK_DIV  = 16,
  parameter int LFSR_W   = 16,
  parameter int LFSR_TAP = 3,
  parameter int OUT_W    = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [7:0]       in_val,
  input  logic             in_wr,
  input  logic             in_pan_wr,
  output logic [OUT_W-1:0] out_l,
  output logic [OUT_W-1:0] out_r
);

  localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam int                SUM_W     = OUT_W + 2;
  localparam logic [SUM_W-1:0]  SAT_MAX   = {2'b00, {OUT_W{1'b1}}};
  localparam logic [LFSR_W-1:0] LFSR_SEED = {1'b1, {(LFSR_W-1){1'b0}}};

  // Reset: asserts asynchronously, releases two clocks after in_rst_n rises.
  logic rst_meta_q, rst_n_q, rst_n;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  assign rst_n = rst_n_q;

  // Registers
  logic              wr_prev_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        latch_q, latch_d;
  logic [TONE_W-1:0] period_q [NUM_TONE];
  logic [TONE_W-1:0] period_d [NUM_TONE];
  logic [3:0]        att_q [NUM_CH];
  logic [3:0]        att_d [NUM_CH];
  noise_rate_e       ns_q, ns_d;
  logic              fb_q, fb_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [6:0]        ndiv_q, ndiv_d;
  logic [7:0]        pan_q, pan_d;
  logic [OUT_W-1:0]  out_l_q, out_l_d;
  logic [OUT_W-1:0]  out_r_q, out_r_d;

  // Generator tick divider
  logic tick;
  assign tick  = (div_q == DIV_MAX);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Byte decoder
  logic       wr_edge;
  logic       noise_wr;
  logic [1:0] cc;
  logic [5:0] hi;

  assign wr_edge = in_wr & ~wr_prev_q;
  assign cc      = in_val[6:5];
  assign hi      = in_val[5:0];

  always_comb begin
    latch_d  = latch_q;
    period_d = period_q;
    att_d    = att_q;
    ns_d     = ns_q;
    fb_d     = fb_q;
    noise_wr = 1'b0;
    if (wr_edge) begin
      if (in_val[7]) begin
        // Latch byte; channels that do not exist are dropped entirely.
        if (cc == CH_NOISE || int'(cc) < NUM_TONE) begin
          latch_d = cc;
          if (in_val[4]) begin
            att_d[cc] = in_val[3:0];
          end else if (cc == CH_NOISE) begin
            noise_wr = 1'b1;
          end else begin
            period_d[cc][3:0] = in_val[3:0];
          end
        end
      end else if (latch_q == CH_NOISE) begin
        // A data byte aimed at the noise channel behaves as a noise write.
        noise_wr = 1'b1;
      end else begin
        period_d[latch_q][TONE_W-1:4] = hi[TONE_W-5:0];
      end
    end
    if (noise_wr) begin
      ns_d = noise_rate_e'(in_val[1:0]);
      fb_d = in_val[2];
    end
  end

  assign pan_d = in_pan_wr ? in_val : pan_q;

  // Tone channels
  logic [NUM_TONE-1:0] tone_bit;
  logic [NUM_TONE-1:0] tone_rise;
  logic                rise_unused;

  for (genvar g = 0; g < NUM_TONE; g++) begin : g_tone
    psg_tone_gen #(
      .TONE_W (TONE_W)
    ) u_tone (
      .clk     (in_clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .period  (period_q[g]),
      .bit_out (tone_bit[g]),
      .rise    (tone_rise[g])
    );
  end

  // Only the last tone channel can clock the noise generator.
  assign rise_unused = ^tone_rise[NUM_TONE-2:0];

  // Noise generator
  logic              do_shift;
  logic              fbit;
  logic [LFSR_W-1:0] lfsr_shift;

  always_comb begin
    ndiv_d = tick ? ndiv_q + 7'd1 : ndiv_q;
    case (ns_q)
      NS_512:  do_shift = tick & (&ndiv_q[4:0]);
      NS_1024: do_shift = tick & (&ndiv_q[5:0]);
      NS_2048: do_shift = tick & (&ndiv_q);
      NS_TONE: do_shift = tone_rise[NUM_TONE-1];
      default: do_shift = 1'b0;
    endcase
    fbit       = fb_q ? (lfsr_q[0] ^ lfsr_q[LFSR_TAP]) : lfsr_q[0];
    lfsr_shift = {fbit, lfsr_q[LFSR_W-1:1]};
    lfsr_d     = lfsr_q;
    // A noise write reseeds and overrides a shift in the same cycle.
    if (noise_wr) begin
      lfsr_d = LFSR_SEED;
    end else if (do_shift) begin
      lfsr_d = (lfsr_shift == '0) ? LFSR_SEED : lfsr_shift;
    end
  end

  // Mixer
  logic [NUM_CH-1:0] chan_bit;
  logic [OUT_W-1:0]  amp;
  logic [SUM_W-1:0]  sum_l, sum_r;

  always_comb begin
    chan_bit = '0;
    for (int t = 0; t < NUM_TONE; t++) begin
      chan_bit[t] = tone_bit[t];
    end
    chan_bit[CH_NOISE] = lfsr_q[0];
    sum_l = '0;
    sum_r = '0;
    amp   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      amp = chan_bit[c] ? OUT_W'(amp_table(att_q[c], OUT_W)) : '0;
      if (pan_q[4+c]) sum_l = sum_l + SUM_W'(amp);
      if (pan_q[c])   sum_r = sum_r + SUM_W'(amp);
    end
    out_l_d = (sum_l > SAT_MAX) ? {OUT_W{1'b1}} : sum_l[OUT_W-1:0];
    out_r_d = (sum_r > SAT_MAX) ? {OUT_W{1'b1}} : sum_r[OUT_W-1:0];
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_q <= 1'b0;
      div_q     <= '0;
      latch_q   <= 2'd0;
      for (int i = 0; i < NUM_TONE; i++) period_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++)   att_q[i]    <= 4'hF;
      ns_q      <= NS_512;
      fb_q      <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      ndiv_q    <= '0;
      pan_q     <= 8'hFF;
      out_l_q   <= '0;
      out_r_q   <= '0;
    end else begin
      wr_prev_q <= in_wr;
      div_q     <= div_d;
      latch_q   <= latch_d;
      period_q  <= period_d;
      att_q     <= att_d;
      ns_q      <= ns_d;
      fb_q      <= fb_d;
      lfsr_q    <= lfsr_d;
      ndiv_q    <= ndiv_d;
      pan_q     <= pan_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
    end
  end

  assign out_l = out_l_q;
  assign out_r = out_r_q;

endmodule

// File: tb/tb_psg_stereo_gen2.sv
// Directed bench for psg_stereo_gen2 with default parameters
// (3 tones, CLK_DIV 16, 16-bit LFSR tap 3, 16-bit output).
module tb_psg_stereo_gen2;

  // AMP[0] = 2^14-1; AMP[6] = 16383 * 10^-0.6 = 4115.2 -> 4115
  localparam logic [15:0] AMP0   = 16'd16383;
  localparam logic [15:0] AMP6   = 16'd4115;
  // All four channels at full level: 4 * 16383, the largest reachable sum
  localparam logic [15:0] ALL4   = 16'd65532;
  // ch0 at att 6 plus ch1, ch2 at att 0
  localparam logic [15:0] MIX3   = 16'd36881;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  val = 8'h00;
  logic        wr = 1'b0;
  logic        pan_wr = 1'b0;
  logic [15:0] out_l, out_r;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  psg_stereo_gen2 dut (
    .in_clk    (clk),
    .in_rst_n  (rst_n),
    .in_val    (val),
    .in_wr     (wr),
    .in_pan_wr (pan_wr),
    .out_l     (out_l),
    .out_r     (out_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic psg_write(input logic [7:0] b);
    @(negedge clk);
    val = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic pan_write(input logic [7:0] b);
    @(negedge clk);
    val    = b;
    pan_wr = 1'b1;
    @(negedge clk);
    pan_wr = 1'b0;
    @(negedge clk);
  endtask

  // Wait (bounded) until out_l shows v; a timeout shows up as a failed check.
  task automatic wait_for(input logic [15:0] v, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (out_l !== v && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_l, v);
  endtask

  // Count consecutive negedge samples with out_l == v.
  task automatic run_len(input logic [15:0] v, input int max_cyc, output int n);
    n = 0;
    while (out_l === v && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] nx;
    nx = {s[0] ^ s[3], s[15:1]};
    if (nx == 16'h0000) nx = 16'h8000;
    return nx;
  endfunction

  initial begin
    int          n;
    logic [15:0] ref_lfsr;

    // Reset and idle
    cycles(3);
    chk("reset_l", out_l, 16'd0);
    chk("reset_r", out_r, 16'd0);
    rst_n = 1'b1;
    cycles(5);
    for (int k = 0; k < 3; k++) begin
      cycles(50);
      chk("idle_l", out_l, 16'd0);
      chk("idle_r", out_r, 16'd0);
    end

    // Tone ch0 period 0x15 = 21 -> 22 ticks = 352 clocks per half period
    psg_write(8'h85);
    psg_write(8'h01);
    psg_write(8'h90);
    wait_for(16'd0, 800, "t2_low");
    wait_for(AMP0, 800, "t2_rise");
    chk("t2_high_r", out_r, AMP0);
    run_len(AMP0, 1000, n);
    chk("t2_high_len", n, 352);
    chk("t2_fall", out_l, 16'd0);
    run_len(16'd0, 1000, n);
    chk("t2_low_len", n, 352);
    run_len(AMP0, 1000, n);
    chk("t2_high_len2", n, 352);

    // Period 0 -> DC high
    psg_write(8'h80);
    psg_write(8'h00);
    psg_write(8'h90);
    cycles(40);
    for (int k = 0; k < 6; k++) begin
      cycles(50);
      chk("t3_dc_l", out_l, AMP0);
    end
    chk("t3_dc_r", out_r, AMP0);

    // Periodic noise, ns 0: shift every 512 clocks, bit0 high 1 of 16 shifts
    psg_write(8'h9F);
    psg_write(8'hE0);
    psg_write(8'hF0);
    chk("t4_start", out_l, 16'd0);
    wait_for(AMP0, 9000, "t4_rise");
    run_len(AMP0, 1000, n);
    chk("t4_high_len", n, 512);
    run_len(16'd0, 9000, n);
    chk("t4_low_len", n, 7680);
    chk("t4_rise2", out_l, AMP0);
    run_len(AMP0, 1000, n);
    chk("t4_high_len2", n, 512);

    // White noise clocked by ch2 (period 2 -> rise every 6 ticks = 96 clocks)
    psg_write(8'hC2);
    psg_write(8'h00);
    psg_write(8'hE7);
    chk("t5_start", out_l, 16'd0);
    ref_lfsr = 16'h8000;
    repeat (15) ref_lfsr = lfsr_step(ref_lfsr);
    wait_for(AMP0, 2000, "t5_first_one");
    chk("t5_ref15", {15'd0, ref_lfsr[0]}, 32'd1);
    cycles(48);
    for (int k = 0; k < 120; k++) begin
      ref_lfsr = lfsr_step(ref_lfsr);
      cycles(96);
      chk("t5_white", out_l, ref_lfsr[0] ? AMP0 : 16'd0);
    end

    // All channels high, then freeze ch2 (period 0) so the noise stops
    psg_write(8'h90);
    psg_write(8'hB0);
    psg_write(8'hD0);
    wait_for(ALL4, 20000, "t6_all_high");
    psg_write(8'hC0);
    cycles(100);
    chk("t6_sum_l", out_l, ALL4);
    chk("t6_sum_r", out_r, ALL4);

    // Panning
    pan_write(8'hF0);
    chk("pan_f0_l", out_l, ALL4);
    chk("pan_f0_r", out_r, 16'd0);
    pan_write(8'h12);
    chk("pan_12_l", out_l, AMP0);
    chk("pan_12_r", out_r, AMP0);
    psg_write(8'h96);
    chk("att6_l", out_l, AMP6);
    chk("att6_r", out_r, AMP0);

    // Same-cycle PSG write (noise att F) and pan write (FF)
    @(negedge clk);
    val    = 8'hFF;
    wr     = 1'b1;
    pan_wr = 1'b1;
    @(negedge clk);
    wr     = 1'b0;
    pan_wr = 1'b0;
    @(negedge clk);
    chk("both_l", out_l, MIX3);
    chk("both_r", out_r, MIX3);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_l", out_l, 16'd0);
    chk("rst_async_r", out_r, 16'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    chk("post_rst_l", out_l, 16'd0);
    chk("post_rst_r", out_r, 16'd0);
    psg_write(8'h90);
    chk("post_rst_dc_l", out_l, AMP0);
    chk("post_rst_dc_r", out_r, AMP0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
